// File: rtl/vx_execute_splitter_if.sv
// Handshake bundle between the dispatch side, the splitter and a narrow execute unit.
// The splitter takes the slave view; whatever drives and consumes it takes the master view.
interface vx_execute_splitter_if #(
    parameter int THREAD_CNT = 4,
    parameter int NUM_LANES  = 1,
    parameter int XLEN       = 32,
    parameter int HDR_WIDTH  = 64,
    parameter int PID_WIDTH  = 2
) ();
    logic                        valid_in;
    logic                        ready_in;
    logic [HDR_WIDTH-1:0]        header_in;
    logic [THREAD_CNT-1:0]       tmask_in;
    logic [THREAD_CNT*XLEN-1:0]  rs1_in;
    logic [THREAD_CNT*XLEN-1:0]  rs2_in;
    logic [THREAD_CNT*XLEN-1:0]  rs3_in;

    logic                        valid_out;
    logic                        ready_out;
    logic [HDR_WIDTH-1:0]        header_out;
    logic [NUM_LANES-1:0]        tmask_out;
    logic [NUM_LANES*XLEN-1:0]   rs1_out;
    logic [NUM_LANES*XLEN-1:0]   rs2_out;
    logic [NUM_LANES*XLEN-1:0]   rs3_out;
    logic [PID_WIDTH-1:0]        pid_out;
    logic                        sop_out;
    logic                        eop_out;

    modport slave (
        input  valid_in, header_in, tmask_in, rs1_in, rs2_in, rs3_in, ready_out,
        output ready_in, valid_out, header_out, tmask_out, rs1_out, rs2_out, rs3_out,
               pid_out, sop_out, eop_out
    );

    modport master (
        output valid_in, header_in, tmask_in, rs1_in, rs2_in, rs3_in, ready_out,
        input  ready_in, valid_out, header_out, tmask_out, rs1_out, rs2_out, rs3_out,
               pid_out, sop_out, eop_out
    );
endinterface

// File: rtl/vx_execute_splitter.sv
// Splits one full-warp execute request into NUM_PACKETS narrow packets tagged with pid/sop/eop,
// optionally skipping packets whose thread-mask slice is empty.
module vx_execute_splitter #(
    parameter int THREAD_CNT  = 4,
    parameter int NUM_LANES   = 1,
    parameter int XLEN        = 32,
    parameter int HDR_WIDTH   = 64,
    parameter int SKIP_EMPTY  = 0,
    parameter int NUM_PACKETS = THREAD_CNT / NUM_LANES,
    parameter int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_execute_splitter_if.slave   sif
);
    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;
    typedef logic [NUM_PACKETS-1:0] pmap_t;

    // A packet is emitted unless skipping is enabled and its mask slice is empty
    function automatic pmap_t emit_map(input logic [THREAD_CNT-1:0] m);
        pmap_t map;
        map = '0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            map[p] = (SKIP_EMPTY == 0) || (|m[p*NUM_LANES +: NUM_LANES]);
        end
        return map;
    endfunction

    // Lowest emitted index; an empty map still yields pid 0 so every instruction emits once
    function automatic logic [PID_WIDTH-1:0] first_idx(input pmap_t map);
        logic [PID_WIDTH-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (map[p] && !found) begin
                idx   = PID_WIDTH'(p);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Returns {found, idx}: the next emitted index strictly above cur, no wrap
    function automatic logic [PID_WIDTH:0] next_idx(input pmap_t map, input logic [PID_WIDTH-1:0] cur);
        logic [PID_WIDTH-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (map[p] && !found && (PID_WIDTH'(p) > cur)) begin
                idx   = PID_WIDTH'(p);
                found = 1'b1;
            end
        end
        return {found, idx};
    endfunction

    state_t                      state_r, state_nxt_s;
    logic [PID_WIDTH-1:0]        pid_r;
    logic [HDR_WIDTH-1:0]        header_r;
    logic [THREAD_CNT-1:0]       tmask_r;
    logic [THREAD_CNT*XLEN-1:0]  rs1_r, rs2_r, rs3_r;

    pmap_t                       map_s;
    logic [PID_WIDTH-1:0]        first_s, next_pid_s;
    logic                        has_next_s;
    logic                        valid_out_s, fire_in_s, fire_out_s, ready_in_s;
    logic                        load_s, advance_s;
    int                          sel_s;

    // Packet sequencing: first/next emitted index of the buffered instruction
    always_comb begin
        map_s                    = emit_map(tmask_r);
        first_s                  = first_idx(map_s);
        {has_next_s, next_pid_s} = next_idx(map_s, pid_r);
    end

    assign valid_out_s = (state_r == SEND);
    assign fire_out_s  = valid_out_s && sif.ready_out;
    assign ready_in_s  = (state_r == IDLE) || (fire_out_s && !has_next_s);
    assign fire_in_s   = sif.valid_in && ready_in_s;
    assign load_s      = fire_in_s;
    assign advance_s   = fire_out_s && has_next_s;

    // Next-state logic; a new instruction can be taken in the cycle the last packet leaves
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fire_in_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (fire_out_s && !has_next_s) begin
                    state_nxt_s = fire_in_s ? SEND : IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, pid and instruction buffer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            pid_r    <= '0;
            header_r <= '0;
            tmask_r  <= '0;
            rs1_r    <= '0;
            rs2_r    <= '0;
            rs3_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                header_r <= sif.header_in;
                tmask_r  <= sif.tmask_in;
                rs1_r    <= sif.rs1_in;
                rs2_r    <= sif.rs2_in;
                rs3_r    <= sif.rs3_in;
                pid_r    <= first_idx(emit_map(sif.tmask_in));
            end else if (advance_s) begin
                pid_r    <= next_pid_s;
            end else begin
                pid_r    <= pid_r;
            end
        end
    end

    // Slice select driven straight from the pid register
    always_comb begin
        sel_s = int'(pid_r);
    end

    assign sif.ready_in   = ready_in_s;
    assign sif.valid_out  = valid_out_s;
    assign sif.header_out = header_r;
    assign sif.tmask_out  = tmask_r[sel_s*NUM_LANES +: NUM_LANES];
    assign sif.rs1_out    = rs1_r[sel_s*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign sif.rs2_out    = rs2_r[sel_s*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign sif.rs3_out    = rs3_r[sel_s*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign sif.pid_out    = pid_r;
    assign sif.sop_out    = valid_out_s && (pid_r == first_s);
    assign sif.eop_out    = valid_out_s && !has_next_s;

endmodule

// File: tb/tb_vx_execute_splitter.sv
// Directed bench for vx_execute_splitter: three instances cover plain split, empty-skip and
// a two-lane variant under backpressure.
module tb_vx_execute_splitter;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    vx_execute_splitter_if #(.THREAD_CNT(4), .NUM_LANES(1), .XLEN(32), .HDR_WIDTH(64), .PID_WIDTH(2)) ifa ();
    vx_execute_splitter_if #(.THREAD_CNT(4), .NUM_LANES(1), .XLEN(32), .HDR_WIDTH(64), .PID_WIDTH(2)) ifb ();
    vx_execute_splitter_if #(.THREAD_CNT(8), .NUM_LANES(2), .XLEN(32), .HDR_WIDTH(64), .PID_WIDTH(2)) ifc ();

    vx_execute_splitter #(.THREAD_CNT(4), .NUM_LANES(1), .XLEN(32), .HDR_WIDTH(64), .SKIP_EMPTY(0))
        dut_a (.clk(clk), .reset_n(reset_n), .sif(ifa));
    vx_execute_splitter #(.THREAD_CNT(4), .NUM_LANES(1), .XLEN(32), .HDR_WIDTH(64), .SKIP_EMPTY(1))
        dut_b (.clk(clk), .reset_n(reset_n), .sif(ifb));
    vx_execute_splitter #(.THREAD_CNT(8), .NUM_LANES(2), .XLEN(32), .HDR_WIDTH(64), .SKIP_EMPTY(0))
        dut_c (.clk(clk), .reset_n(reset_n), .sif(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        ifa.valid_in = 1'b0; ifa.header_in = '0; ifa.tmask_in = '0; ifa.ready_out = 1'b0;
        ifa.rs1_in = '0; ifa.rs2_in = '0; ifa.rs3_in = '0;
        ifb.valid_in = 1'b0; ifb.header_in = '0; ifb.tmask_in = '0; ifb.ready_out = 1'b0;
        ifb.rs1_in = '0; ifb.rs2_in = '0; ifb.rs3_in = '0;
        ifc.valid_in = 1'b0; ifc.header_in = '0; ifc.tmask_in = '0; ifc.ready_out = 1'b0;
        ifc.rs1_in = '0; ifc.rs2_in = '0; ifc.rs3_in = '0;
    endtask

    task automatic test_reset();
        checks++; if (ifa.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_a got %b exp 0", ifa.valid_out); end
        checks++; if (ifa.ready_in !== 1'b1) begin errors++; $display("FAIL rst_ready_a got %b exp 1", ifa.ready_in); end
        checks++; if (ifa.pid_out !== 2'd0) begin errors++; $display("FAIL rst_pid_a got %0d exp 0", ifa.pid_out); end
        checks++; if ({ifa.sop_out, ifa.eop_out} !== 2'b00) begin errors++; $display("FAIL rst_sop_eop_a got %b exp 00", {ifa.sop_out, ifa.eop_out}); end
        checks++; if (ifa.rs1_out !== 32'h0 || ifa.header_out !== 64'h0 || ifa.tmask_out !== 1'b0) begin
            errors++; $display("FAIL rst_data_a got rs1=%h hdr=%h tm=%b exp zeros", ifa.rs1_out, ifa.header_out, ifa.tmask_out); end
        checks++; if (ifb.valid_out !== 1'b0 || ifb.ready_in !== 1'b1) begin
            errors++; $display("FAIL rst_b got v=%b r=%b exp v=0 r=1", ifb.valid_out, ifb.ready_in); end
        checks++; if (ifc.valid_out !== 1'b0 || ifc.ready_in !== 1'b1 || ifc.rs1_out !== 64'h0) begin
            errors++; $display("FAIL rst_c got v=%b r=%b rs1=%h exp 0/1/0", ifc.valid_out, ifc.ready_in, ifc.rs1_out); end
    endtask

    task automatic test_split_basic();
        logic [3:0] tm;
        tm = 4'b1010;
        step();
        ifa.valid_in = 1'b1; ifa.tmask_in = tm; ifa.header_in = 64'hDEAD_BEEF_0123_4567; ifa.ready_out = 1'b1;
        for (int t = 0; t < 4; t++) begin
            ifa.rs1_in[t*32 +: 32] = 32'h11 * t;
            ifa.rs2_in[t*32 +: 32] = 32'h200 + t;
            ifa.rs3_in[t*32 +: 32] = 32'h300 + t;
        end
        #1;
        checks++; if (ifa.ready_in !== 1'b1) begin errors++; $display("FAIL basic_ready_idle got %b exp 1", ifa.ready_in); end
        step();
        ifa.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (ifa.valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid k=%0d got %b exp 1", k, ifa.valid_out); end
            checks++; if (ifa.pid_out !== 2'(k)) begin errors++; $display("FAIL basic_pid k=%0d got %0d exp %0d", k, ifa.pid_out, k); end
            checks++; if (ifa.tmask_out !== tm[k]) begin errors++; $display("FAIL basic_tmask k=%0d got %b exp %b", k, ifa.tmask_out, tm[k]); end
            checks++; if (ifa.rs1_out !== 32'(32'h11 * k)) begin errors++; $display("FAIL basic_rs1 k=%0d got %h exp %h", k, ifa.rs1_out, 32'h11 * k); end
            checks++; if (ifa.rs2_out !== 32'(32'h200 + k) || ifa.rs3_out !== 32'(32'h300 + k)) begin
                errors++; $display("FAIL basic_rs23 k=%0d got %h/%h", k, ifa.rs2_out, ifa.rs3_out); end
            checks++; if (ifa.sop_out !== (k == 0) || ifa.eop_out !== (k == 3)) begin
                errors++; $display("FAIL basic_sop_eop k=%0d got %b%b exp %b%b", k, ifa.sop_out, ifa.eop_out, k == 0, k == 3); end
            checks++; if (ifa.ready_in !== (k == 3)) begin errors++; $display("FAIL basic_ready_in k=%0d got %b exp %b", k, ifa.ready_in, k == 3); end
            checks++; if (ifa.header_out !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL basic_header k=%0d got %h", k, ifa.header_out); end
            step();
        end
        checks++; if (ifa.valid_out !== 1'b0 || ifa.ready_in !== 1'b1) begin
            errors++; $display("FAIL basic_drain got v=%b r=%b exp v=0 r=1", ifa.valid_out, ifa.ready_in); end
    endtask

    task automatic test_skip_empty();
        logic [1:0]  exp_pid [2];
        logic [31:0] exp_rs1 [2];
        exp_pid = '{2'd1, 2'd3};
        exp_rs1 = '{32'h11, 32'h33};
        step();
        ifb.valid_in = 1'b1; ifb.tmask_in = 4'b1010; ifb.ready_out = 1'b1; ifb.header_in = 64'h55;
        for (int t = 0; t < 4; t++) ifb.rs1_in[t*32 +: 32] = 32'h11 * t;
        step();
        ifb.valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (ifb.valid_out !== 1'b1 || ifb.pid_out !== exp_pid[k]) begin
                errors++; $display("FAIL skip_pid k=%0d got v=%b pid=%0d exp pid=%0d", k, ifb.valid_out, ifb.pid_out, exp_pid[k]); end
            checks++; if (ifb.sop_out !== (k == 0) || ifb.eop_out !== (k == 1)) begin
                errors++; $display("FAIL skip_sop_eop k=%0d got %b%b exp %b%b", k, ifb.sop_out, ifb.eop_out, k == 0, k == 1); end
            checks++; if (ifb.rs1_out !== exp_rs1[k] || ifb.tmask_out !== 1'b1) begin
                errors++; $display("FAIL skip_data k=%0d got rs1=%h tm=%b exp rs1=%h tm=1", k, ifb.rs1_out, ifb.tmask_out, exp_rs1[k]); end
            step();
        end
        checks++; if (ifb.valid_out !== 1'b0) begin errors++; $display("FAIL skip_drain got %b exp 0", ifb.valid_out); end
        ifb.valid_in = 1'b1; ifb.tmask_in = 4'b0000;
        step();
        ifb.valid_in = 1'b0;
        checks++; if (ifb.valid_out !== 1'b1 || ifb.pid_out !== 2'd0 || ifb.tmask_out !== 1'b0) begin
            errors++; $display("FAIL skip_zero_pkt got v=%b pid=%0d tm=%b exp 1/0/0", ifb.valid_out, ifb.pid_out, ifb.tmask_out); end
        checks++; if (ifb.sop_out !== 1'b1 || ifb.eop_out !== 1'b1 || ifb.ready_in !== 1'b1) begin
            errors++; $display("FAIL skip_zero_flags got sop=%b eop=%b rdy=%b exp 111", ifb.sop_out, ifb.eop_out, ifb.ready_in); end
        step();
        checks++; if (ifb.valid_out !== 1'b0) begin errors++; $display("FAIL skip_zero_once got %b exp 0", ifb.valid_out); end
    endtask

    task automatic test_backpressure();
        step();
        ifc.valid_in = 1'b1; ifc.tmask_in = 8'b1001_1100; ifc.ready_out = 1'b1; ifc.header_in = 64'hC0FFEE;
        for (int t = 0; t < 8; t++) ifc.rs1_in[t*32 +: 32] = 32'h100 + t;
        step();
        ifc.valid_in = 1'b0;
        checks++; if (ifc.valid_out !== 1'b1 || ifc.pid_out !== 2'd0 || ifc.sop_out !== 1'b1 || ifc.tmask_out !== 2'b00
                      || ifc.rs1_out !== 64'h00000101_00000100) begin
            errors++; $display("FAIL bp_pid0 got v=%b pid=%0d sop=%b tm=%b rs1=%h", ifc.valid_out, ifc.pid_out, ifc.sop_out, ifc.tmask_out, ifc.rs1_out); end
        step();
        ifc.ready_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ifc.valid_out !== 1'b1 || ifc.pid_out !== 2'd1) begin
                errors++; $display("FAIL bp_hold_pid i=%0d got v=%b pid=%0d exp 1/1", i, ifc.valid_out, ifc.pid_out); end
            checks++; if (ifc.tmask_out !== 2'b11 || ifc.rs1_out !== 64'h00000103_00000102) begin
                errors++; $display("FAIL bp_hold_data i=%0d got tm=%b rs1=%h exp 11/0000010300000102", i, ifc.tmask_out, ifc.rs1_out); end
            checks++; if (ifc.sop_out !== 1'b0 || ifc.eop_out !== 1'b0 || ifc.ready_in !== 1'b0) begin
                errors++; $display("FAIL bp_hold_flags i=%0d got sop=%b eop=%b rdy=%b exp 000", i, ifc.sop_out, ifc.eop_out, ifc.ready_in); end
            if (i < 3) step();
        end
        ifc.ready_out = 1'b1;
        step();
        checks++; if (ifc.pid_out !== 2'd2 || ifc.tmask_out !== 2'b01 || ifc.rs1_out !== 64'h00000105_00000104 || ifc.eop_out !== 1'b0) begin
            errors++; $display("FAIL bp_pid2 got pid=%0d tm=%b rs1=%h eop=%b", ifc.pid_out, ifc.tmask_out, ifc.rs1_out, ifc.eop_out); end
        step();
        checks++; if (ifc.pid_out !== 2'd3 || ifc.tmask_out !== 2'b10 || ifc.eop_out !== 1'b1 || ifc.header_out !== 64'hC0FFEE) begin
            errors++; $display("FAIL bp_pid3 got pid=%0d tm=%b eop=%b hdr=%h", ifc.pid_out, ifc.tmask_out, ifc.eop_out, ifc.header_out); end
        step();
        checks++; if (ifc.valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ifc.valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  tm1;
        logic [31:0] exp_rs1;
        logic        exp_tm;
        tm1 = 4'b1010;
        step();
        ifa.valid_in = 1'b1; ifa.tmask_in = tm1; ifa.ready_out = 1'b1; ifa.header_in = 64'h1;
        for (int t = 0; t < 4; t++) ifa.rs1_in[t*32 +: 32] = 32'h11 * t;
        step();
        ifa.tmask_in = 4'b1111; ifa.header_in = 64'h2;
        for (int t = 0; t < 4; t++) ifa.rs1_in[t*32 +: 32] = 32'hA0 + t;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) ifa.valid_in = 1'b0;
            exp_rs1 = (k < 4) ? 32'(32'h11 * k) : 32'(32'hA0 + k - 4);
            exp_tm  = (k < 4) ? tm1[k] : 1'b1;
            checks++; if (ifa.valid_out !== 1'b1 || ifa.pid_out !== 2'(k % 4)) begin
                errors++; $display("FAIL b2b_pid k=%0d got v=%b pid=%0d exp pid=%0d", k, ifa.valid_out, ifa.pid_out, k % 4); end
            checks++; if (ifa.rs1_out !== exp_rs1 || ifa.tmask_out !== exp_tm) begin
                errors++; $display("FAIL b2b_data k=%0d got rs1=%h tm=%b exp rs1=%h tm=%b", k, ifa.rs1_out, ifa.tmask_out, exp_rs1, exp_tm); end
            checks++; if (ifa.sop_out !== (k % 4 == 0) || ifa.eop_out !== (k % 4 == 3) || ifa.ready_in !== (k % 4 == 3)) begin
                errors++; $display("FAIL b2b_flags k=%0d got sop=%b eop=%b rdy=%b", k, ifa.sop_out, ifa.eop_out, ifa.ready_in); end
            checks++; if (ifa.header_out !== ((k < 4) ? 64'h1 : 64'h2)) begin
                errors++; $display("FAIL b2b_header k=%0d got %h", k, ifa.header_out); end
            step();
        end
        checks++; if (ifa.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", ifa.valid_out); end
    endtask

    task automatic test_reset_mid();
        step();
        ifa.valid_in = 1'b1; ifa.tmask_in = 4'b1111; ifa.ready_out = 1'b1;
        for (int t = 0; t < 4; t++) ifa.rs1_in[t*32 +: 32] = 32'h40 + t;
        step();
        ifa.valid_in = 1'b0;
        step();
        step();
        checks++; if (ifa.valid_out !== 1'b1 || ifa.pid_out !== 2'd2) begin
            errors++; $display("FAIL rmid_pre got v=%b pid=%0d exp 1/2", ifa.valid_out, ifa.pid_out); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (ifa.valid_out !== 1'b0 || ifa.pid_out !== 2'd0 || ifa.eop_out !== 1'b0) begin
            errors++; $display("FAIL rmid_async got v=%b pid=%0d eop=%b exp 0/0/0", ifa.valid_out, ifa.pid_out, ifa.eop_out); end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step();
        checks++; if (ifa.valid_out !== 1'b0 || ifa.ready_in !== 1'b1) begin
            errors++; $display("FAIL rmid_idle got v=%b r=%b exp 0/1", ifa.valid_out, ifa.ready_in); end
        ifa.valid_in = 1'b1; ifa.tmask_in = 4'b1010;
        step();
        ifa.valid_in = 1'b0;
        checks++; if (ifa.valid_out !== 1'b1 || ifa.pid_out !== 2'd0 || ifa.sop_out !== 1'b1 || ifa.rs1_out !== 32'h40) begin
            errors++; $display("FAIL rmid_restart got v=%b pid=%0d sop=%b rs1=%h exp 1/0/1/40", ifa.valid_out, ifa.pid_out, ifa.sop_out, ifa.rs1_out); end
        for (int k = 0; k < 4; k++) step();
        checks++; if (ifa.valid_out !== 1'b0) begin errors++; $display("FAIL rmid_drain got %b exp 0", ifa.valid_out); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        init_inputs();
        reset_n = 1'b0;
        #2;
        test_reset();
        #10;
        reset_n = 1'b1;
        test_split_basic();
        test_skip_empty();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
